// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : shared widths, reset PC default and redirect source encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_J    = 2'd2,
    REDIR_JR   = 2'd3
  } redir_src_e;

  function automatic logic [WORD_W-1:0] branch_target(
    input logic [WORD_W-1:0] pc_plus4,
    input logic [15:0]       offset
  );
    logic [WORD_W-1:0] ext;
    ext = {{(WORD_W-18){offset[15]}}, offset, 2'b00};
    return pc_plus4 + ext;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// next_pc_sel : redirect target computation and jr > j > branch priority mux
// Rev 1.0
// ---------------------------------------------------------------------------
module next_pc_sel
  import mips_pkg::*;
(
  input  logic              i_id_valid,
  input  logic [WORD_W-1:0] i_id_pc_plus4,
  input  logic              i_br_taken,
  input  logic [15:0]       i_br_offset,
  input  logic              i_jump,
  input  logic [25:0]       i_jump_index,
  input  logic              i_jump_reg,
  input  logic [WORD_W-1:0] i_jr_target,
  output logic              o_redirect_valid,
  output logic [WORD_W-1:0] o_target,
  output logic              o_misaligned
);

  redir_src_e w_src;

  // Redirects only make sense for a real instruction sitting in IF/ID.
  always_comb begin
    w_src = REDIR_NONE;
    if (i_id_valid) begin
      if (i_jump_reg)      w_src = REDIR_JR;
      else if (i_jump)     w_src = REDIR_J;
      else if (i_br_taken) w_src = REDIR_BR;
    end
  end

  always_comb begin
    o_target = '0;
    case (w_src)
      REDIR_JR: o_target = i_jr_target;
      REDIR_J:  o_target = {i_id_pc_plus4[31:28], i_jump_index, 2'b00};
      REDIR_BR: o_target = branch_target(i_id_pc_plus4, i_br_offset);
      default:  o_target = '0;
    endcase
  end

  assign o_redirect_valid = (w_src != REDIR_NONE);
  assign o_misaligned     = o_redirect_valid && (o_target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : PC, IF/ID register, fetch counter and halt/misalign flags
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic        halted,
  output logic        misalign_err
);

  // One extra bit so the byte limit cannot overflow for large memories.
  localparam logic [WORD_W:0] c_FETCH_LIMIT = {1'b0, WORD_W'(IMEM_WORDS)} << 2;

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_id_instr;
  logic [WORD_W-1:0] r_id_pc_plus4;
  logic              r_id_valid;
  logic [WORD_W-1:0] r_fetch_count;
  logic              r_halted;
  logic              r_misalign_err;

  logic              w_redirect_valid;
  logic [WORD_W-1:0] w_target;
  logic              w_misaligned;
  logic              w_at_limit;
  logic [WORD_W-1:0] w_pc_plus4;

  next_pc_sel u_next_pc_sel (
    .i_id_valid       (r_id_valid),
    .i_id_pc_plus4    (r_id_pc_plus4),
    .i_br_taken       (br_taken),
    .i_br_offset      (br_offset),
    .i_jump           (jump),
    .i_jump_index     (jump_index),
    .i_jump_reg       (jump_reg),
    .i_jr_target      (jr_target),
    .o_redirect_valid (w_redirect_valid),
    .o_target         (w_target),
    .o_misaligned     (w_misaligned)
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_at_limit = ({1'b0, r_pc} >= c_FETCH_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_id_instr     <= '0;
      r_id_pc_plus4  <= '0;
      r_id_valid     <= 1'b0;
      r_fetch_count  <= '0;
      r_halted       <= 1'b0;
      r_misalign_err <= 1'b0;
    end else if (r_halted) begin
      r_id_valid <= 1'b0;
    end else if (w_redirect_valid && w_misaligned) begin
      r_misalign_err <= 1'b1;
      r_halted       <= 1'b1;
      r_id_valid     <= 1'b0;
    end else if (w_redirect_valid) begin
      // Redirect overrides stall; the fetched slot becomes a bubble.
      r_pc       <= w_target;
      r_id_valid <= 1'b0;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (w_at_limit) begin
      r_halted   <= 1'b1;
      r_id_valid <= 1'b0;
    end else begin
      r_id_instr    <= imem_instr;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_pc          <= w_pc_plus4;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign id_instr     = r_id_instr;
  assign id_pc_plus4  = r_id_pc_plus4;
  assign id_valid     = r_id_valid;
  assign fetch_count  = r_fetch_count;
  assign halted       = r_halted;
  assign misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_taken, jump, jump_reg;
  logic [15:0] br_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr, imem_instr, pc, id_instr, id_pc_plus4, fetch_count;
  logic        id_valid, halted, misalign_err;

  logic        s_reset;
  logic        s_zero1;
  logic [15:0] s_zero16;
  logic [25:0] s_zero26;
  logic [31:0] s_zero32;
  logic [31:0] s_imem_addr, s_imem_instr, s_pc, s_id_instr, s_id_pc_plus4, s_fetch_count;
  logic        s_id_valid, s_halted, s_misalign_err;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2002_0004;
      32'h0000_0004: return 32'hac02_0004;
      default:       return {8'hE0, a[23:0]};
    endcase
  endfunction

  assign imem_instr   = imem(imem_addr);
  assign s_imem_instr = imem(s_imem_addr);

  // Large memory so that high jump targets remain fetchable.
  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32'h2000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .fetch_count(fetch_count),
    .halted(halted), .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
    .clk(clk), .reset(s_reset), .stall(s_zero1), .br_taken(s_zero1), .br_offset(s_zero16),
    .jump(s_zero1), .jump_index(s_zero26), .jump_reg(s_zero1), .jr_target(s_zero32),
    .imem_addr(s_imem_addr), .imem_instr(s_imem_instr), .pc(s_pc), .id_instr(s_id_instr),
    .id_pc_plus4(s_id_pc_plus4), .id_valid(s_id_valid), .fetch_count(s_fetch_count),
    .halted(s_halted), .misalign_err(s_misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    br_taken = 1'b0; br_offset = '0; jump = 1'b0; jump_index = '0;
    jump_reg = 1'b0; jr_target = '0;
  endtask

  task automatic chk_main(input string tag, input logic [31:0] e_pc, input logic e_valid,
                          input logic [31:0] e_fc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, e_valid});
    chk({tag, ".count"}, fetch_count, e_fc);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; clr_redir();
    s_reset = 1'b1; s_zero1 = 1'b0; s_zero16 = '0; s_zero26 = '0; s_zero32 = '0;

    step(2);
    chk_main("reset", 32'h0, 1'b0, 32'd0);
    chk("reset.halted", {31'd0, halted}, 32'd0);
    chk("reset.misalign", {31'd0, misalign_err}, 32'd0);
    chk("reset.imem_addr", imem_addr, 32'h0);

    reset = 1'b0;
    step(1);
    chk_main("fetch1", 32'h4, 1'b1, 32'd1);
    chk("fetch1.instr", id_instr, 32'h2002_0004);
    chk("fetch1.pc4", id_pc_plus4, 32'h4);
    step(1);
    chk_main("fetch2", 32'h8, 1'b1, 32'd2);
    chk("fetch2.instr", id_instr, 32'hac02_0004);

    stall = 1'b1;
    step(3);
    chk_main("stall", 32'h8, 1'b1, 32'd2);
    chk("stall.instr", id_instr, 32'hac02_0004);
    stall = 1'b0;
    step(1);
    chk_main("unstall", 32'hC, 1'b1, 32'd3);
    chk("unstall.instr", id_instr, imem(32'h8));

    step(3);
    chk("pre_br.pc4", id_pc_plus4, 32'h18);
    br_taken = 1'b1; br_offset = 16'hFFFE;
    step(1);
    chk_main("br_back", 32'h10, 1'b0, 32'd6);
    step(1);  // br_taken still high during the bubble: must be ignored
    chk_main("bubble_ign", 32'h14, 1'b1, 32'd7);
    chk("bubble_ign.pc4", id_pc_plus4, 32'h14);
    br_taken = 1'b0;
    step(1);
    chk("pre_br2.pc4", id_pc_plus4, 32'h18);
    br_taken = 1'b1; br_offset = 16'h0001; stall = 1'b1;
    step(1);
    chk_main("br_fwd_stall", 32'h1C, 1'b0, 32'd8);
    clr_redir(); stall = 1'b0;
    step(1);
    chk_main("after_br", 32'h20, 1'b1, 32'd9);

    jump_reg = 1'b1; jr_target = 32'h24; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    br_taken = 1'b1; br_offset = 16'h0005;
    step(1);
    chk_main("jr_wins", 32'h24, 1'b0, 32'd9);
    clr_redir();
    step(1);
    jump = 1'b1; jump_index = 26'h000_0100; br_taken = 1'b1; br_offset = 16'h0001;
    step(1);
    chk_main("j_over_br", 32'h400, 1'b0, 32'd10);
    clr_redir();
    step(1);
    jump_reg = 1'b1; jr_target = 32'h4000_000C;
    step(1);
    chk("jr_high.pc", pc, 32'h4000_000C);
    clr_redir();
    step(1);
    chk("fetch_high.pc4", id_pc_plus4, 32'h4000_0010);
    chk("fetch_high.instr", id_instr, imem(32'h4000_000C));
    jump = 1'b1; jump_index = 26'h000_0010;
    step(1);
    chk_main("j_region", 32'h4000_0040, 1'b0, 32'd12);
    clr_redir();

    step(1);
    jump_reg = 1'b1; jr_target = 32'h22;
    step(1);
    chk_main("misalign", 32'h4000_0044, 1'b0, 32'd13);
    chk("misalign.err", {31'd0, misalign_err}, 32'd1);
    chk("misalign.halted", {31'd0, halted}, 32'd1);
    clr_redir();
    step(3);
    chk_main("halt_frozen", 32'h4000_0044, 1'b0, 32'd13);
    chk("halt_frozen.instr", id_instr, imem(32'h4000_0040));
    chk("halt_frozen.halted", {31'd0, halted}, 32'd1);

    reset = 1'b1; stall = 1'b1; br_taken = 1'b1; br_offset = 16'h0003;
    step(1);
    chk_main("rst_mid", 32'h0, 1'b0, 32'd0);
    chk("rst_mid.instr", id_instr, 32'h0);
    chk("rst_mid.pc4", id_pc_plus4, 32'h0);
    chk("rst_mid.flags", {30'd0, halted, misalign_err}, 32'd0);
    reset = 1'b0; stall = 1'b0; clr_redir();
    step(1);
    chk_main("rst_refetch", 32'h4, 1'b1, 32'd1);

    s_reset = 1'b0;
    step(4);
    chk("eom4.pc", s_pc, 32'h10);
    chk("eom4.count", s_fetch_count, 32'd4);
    chk("eom4.halted", {31'd0, s_halted}, 32'd0);
    chk("eom4.instr", s_id_instr, imem(32'hC));
    step(1);
    chk("eom.halted", {31'd0, s_halted}, 32'd1);
    chk("eom.valid", {31'd0, s_id_valid}, 32'd0);
    chk("eom.pc", s_pc, 32'h10);
    chk("eom.count", s_fetch_count, 32'd4);
    step(2);
    chk("eom_hold.count", s_fetch_count, 32'd4);
    s_reset = 1'b1;
    step(1);
    chk("eom_rst.pc", s_pc, 32'h0);
    chk("eom_rst.count", s_fetch_count, 32'd0);
    chk("eom_rst.flags", {30'd0, s_halted, s_id_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned byte address into instruction memory.
- Latches the returned word into an IF/ID register with a valid flag.
- Applies branch/jump/jr redirects from decode, plus stall, flush-on-redirect and halt handling.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 1024, instruction memory depth in 32-bit words; fetch limit is IMEM_WORDS*4 bytes

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID contents
br_taken  input  1  decode resolved beq/bne as taken for the instruction in IF/ID
br_offset  input  16  raw immediate of that branch
jump  input  1  j/jal in IF/ID
jump_index  input  26  instr_index field of the jump
jump_reg  input  1  jr in IF/ID
jr_target  input  32  register value for jr
imem_addr  output  32  byte address to instruction memory (= pc)
imem_instr  input  32  word returned combinationally by instruction memory
pc  output  32  current fetch PC
id_instr  output  32  IF/ID instruction
id_pc_plus4  output  32  IF/ID PC+4
id_valid  output  1  IF/ID holds a real instruction
fetch_count  output  32  number of instructions latched valid since reset
halted  output  1  sticky, fetch stopped
misalign_err  output  1  sticky, redirect target low bits nonzero

Behaviour:
- All state updates on the rising clk edge; reset has priority over everything.
- Reset values:
  - pc = RESET_PC
  - id_instr = 0, id_pc_plus4 = 0, id_valid = 0
  - fetch_count = 0, halted = 0, misalign_err = 0
- imem_addr = pc, combinational.
- Redirect target is computed from id_pc_plus4, and only when id_valid = 1:
  - jr: jr_target
  - j: {id_pc_plus4[31:28], jump_index, 2'b00}
  - branch: id_pc_plus4 + (sign-extended br_offset << 2), modulo 2^32
- Redirect source priority: jump_reg > jump > br_taken. Redirect inputs are ignored when id_valid = 0.
- Next-state priority per cycle:
  1. halted: pc, IF/ID and fetch_count frozen; id_valid forced 0.
  2. Valid redirect with target[1:0] != 0:
     - misalign_err = 1, halted = 1, id_valid = 0
     - pc unchanged
  3. Valid redirect, aligned target (wins over stall):
     - pc = target, id_valid = 0 (one-bubble flush)
     - fetch_count unchanged
  4. stall: pc, IF/ID and fetch_count hold.
  5. pc >= IMEM_WORDS*4: halted = 1, id_valid = 0, no fetch.
  6. Normal:
     - id_instr = imem_instr, id_pc_plus4 = pc + 4, id_valid = 1
     - pc = pc + 4, fetch_count += 1 (wraps at 2^32)
- Latency: address presented in cycle N appears on id_instr / id_valid in cycle N+1.
- Taken-redirect penalty is exactly one bubble cycle.
- pc is always word aligned; the low two bits are never set by normal flow.
- pc + 4 wrapping to 0 at 2^32 is permitted but unreachable while IMEM_WORDS*4 < 2^32, since the limit check halts first.
- Reset asserted mid-redirect or mid-stall: reset values next cycle, no partial update.
- Reset is the only way to clear halted.

Decomposition:
- Shared package mips_pkg:
  - WORD_W = 32
  - RESET_PC default
  - typedef for redirect source encoding: NONE, BR, J, JR
- Natural sub-module: next_pc_sel.
  - Combinational target computation and priority mux.
  - Outputs redirect_valid, target, misaligned.
- fetch_unit holds the PC, IF/ID registers, counter and halt flags.

Test Plan:
- Reset: reset=1 for 2 cycles → pc=0, id_valid=0, fetch_count=0, halted=0. Release with memory words 20020004, ac020004 → cycle 1: id_instr=20020004, id_pc_plus4=4, pc=4. Cycle 2: id_instr=ac020004, fetch_count=2.
- Stall: assert stall for 3 cycles with pc=8 → pc, id_instr and fetch_count unchanged. Deassert → next fetch from 8.
- Branch: id_pc_plus4=0x18, br_taken=1, br_offset=16'h0001 → pc=0x1C next cycle, id_valid=0 for one cycle. br_offset=16'hFFFE → pc=0x10.
- Jump and jr:
  - id_pc_plus4=0x40000010, jump_index=26'h0000010 → pc=0x40000040.
  - jr_target=0x24 with jump=1 also set → pc=0x24 (jr wins).
  - stall=1 concurrent with a taken branch → redirect still applies.
- Misaligned jr: jr_target=0x22 → misalign_err=1, halted=1, pc frozen, id_valid=0 thereafter until reset.
- End of memory: IMEM_WORDS=4, no redirects → after 4 fetches pc=0x10, halted=1 next cycle, fetch_count=4. Then reset → all cleared.
